// File: rtl/block_tracker.sv
// -----------------------------------------------------------------------------
// block_tracker
//
// Framing stage between the AXI-Stream pixel input and the chaos crypto core.
// It counts 32-bit blocks against a programmed image length and drives the
// controller's first/last-block status. It forwards data through a 2-entry
// skid buffer, tags the final block of each image with m_axis_tlast, and
// pulses frame_done once that block has left on the m side. After every image
// it rearms itself, so back-to-back images need no software action.
//
// Parameters:
//   DATA_W          stream data width
//   CNT_W           block-counter width (max image length 2^CNT_W-1 blocks)
//
// Ports:
//   clk             system clock
//   reset           synchronous, active-high reset
//   cfg_num_blocks  image length in blocks, sampled only on cfg_load
//   cfg_load        one-cycle pulse: latch length, flush buffer, start frame
//   s_axis_*        input stream (tready is registered)
//   m_axis_*        output stream; tlast marks the final block of the image
//   is_first_block  current input beat has index 0 (RUN only)
//   is_last_block   current input beat has index num_blocks-1 (RUN only)
//   frame_done      one-cycle pulse after the last block handshakes on m side
//   cfg_err         sticky: the most recent cfg_load carried length 0
//   blk_index       input block counter (debug)
// -----------------------------------------------------------------------------
module block_tracker #(
  parameter int DATA_W = 32,
  parameter int CNT_W  = 20
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [CNT_W-1:0]  cfg_num_blocks,
  input  logic              cfg_load,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  output logic [DATA_W-1:0] m_axis_tdata,
  output logic              m_axis_tvalid,
  input  logic              m_axis_tready,
  output logic              m_axis_tlast,
  output logic              is_first_block,
  output logic              is_last_block,
  output logic              frame_done,
  output logic              cfg_err,
  output logic [CNT_W-1:0]  blk_index
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  logic [CNT_W-1:0]  num_blocks;
  logic [CNT_W-1:0]  last_idx;

  // The main register is the m_axis_* output set itself; the skid register
  // holds one extra beat accepted while main was stalled.
  logic [DATA_W-1:0] skid_data;
  logic              skid_last;
  logic              skid_valid;
  logic              skid_next_valid;

  logic              s_hs;
  logic              m_hs;
  logic              beat_last;
  logic              main_free;
  logic              cfg_zero;

  // ---------------------------------------------------------------------------
  // Status flags: pure functions of registered state, independent of tvalid.
  // ---------------------------------------------------------------------------
  assign last_idx       = num_blocks - CNT_W'(1);
  assign is_first_block = (state == RUN) && (blk_index == '0);
  assign is_last_block  = (state == RUN) && (blk_index == last_idx);

  // ---------------------------------------------------------------------------
  // Handshake decode and next-state computation.
  // ---------------------------------------------------------------------------
  // NOTE: every signal written in this always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    s_hs            = s_axis_tvalid && s_axis_tready;
    m_hs            = m_axis_tvalid && m_axis_tready;
    beat_last       = (blk_index == last_idx);
    main_free       = !m_axis_tvalid || m_hs;
    cfg_zero        = (cfg_num_blocks == '0);
    state_next      = state;
    skid_next_valid = 1'b0;

    if (cfg_load) begin
      state_next      = cfg_zero ? IDLE : RUN;
      skid_next_valid = 1'b0;
    end else begin
      unique case (state)
        IDLE:    state_next = IDLE;
        RUN:     if (s_hs && beat_last) state_next = DRAIN;
        DRAIN:   if (m_hs && m_axis_tlast) state_next = RUN;
        default: state_next = IDLE;
      endcase

      // s_axis_tready is low whenever the skid is occupied, so a new beat and
      // a skid-to-main move never happen in the same cycle.
      if (main_free) skid_next_valid = 1'b0;
      else           skid_next_valid = skid_valid || s_hs;
    end
  end

  // ---------------------------------------------------------------------------
  // Registered FSM, counter, skid buffer and status outputs.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      num_blocks    <= '0;
      blk_index     <= '0;
      s_axis_tready <= 1'b0;
      m_axis_tvalid <= 1'b0;
      m_axis_tlast  <= 1'b0;
      m_axis_tdata  <= '0;
      skid_valid    <= 1'b0;
      skid_last     <= 1'b0;
      frame_done    <= 1'b0;
      cfg_err       <= 1'b0;
      // NOTE: skid_data is a pure datapath register qualified by skid_valid,
      // so it is deliberately left out of reset.
    end else begin
      frame_done <= 1'b0;

      if (cfg_load) begin
        // A new configuration wins over everything: flush both buffer
        // entries and drop any beat handshaking on either side this cycle.
        num_blocks    <= cfg_num_blocks;
        blk_index     <= '0;
        m_axis_tvalid <= 1'b0;
        m_axis_tlast  <= 1'b0;
        skid_valid    <= 1'b0;
        cfg_err       <= cfg_zero;
      end else begin
        // Block counter: wraps only through the last-block reset.
        if (s_hs) begin
          if (beat_last) blk_index <= '0;
          else           blk_index <= blk_index + CNT_W'(1);
        end

        // Skid buffer: refill main from skid first, then from the input.
        if (main_free) begin
          if (skid_valid) begin
            m_axis_tdata  <= skid_data;
            m_axis_tlast  <= skid_last;
            m_axis_tvalid <= 1'b1;
            skid_valid    <= 1'b0;
          end else if (s_hs) begin
            m_axis_tdata  <= s_axis_tdata;
            m_axis_tlast  <= beat_last;
            m_axis_tvalid <= 1'b1;
          end else begin
            m_axis_tvalid <= 1'b0;
            m_axis_tlast  <= 1'b0;
          end
        end else if (s_hs) begin
          skid_data  <= s_axis_tdata;
          skid_last  <= beat_last;
          skid_valid <= 1'b1;
        end

        // The last-tagged beat can only leave while draining.
        frame_done <= (state == DRAIN) && m_hs && m_axis_tlast;
      end

      state         <= state_next;
      s_axis_tready <= (state_next == RUN) && !skid_next_valid;
    end
  end

endmodule

// File: tb/tb_block_tracker.sv
// -----------------------------------------------------------------------------
// tb_block_tracker
//
// Directed bench for block_tracker. Inputs are driven 1 time unit after the
// rising edge and outputs are sampled at that same point, so every value seen
// is the settled post-edge register state. A small scoreboard records beats
// accepted on the s side and delivered on the m side.
// -----------------------------------------------------------------------------
module tb_block_tracker;

  localparam int DATA_W = 32;
  localparam int CNT_W  = 20;

  logic              clk;
  logic              reset;
  logic [CNT_W-1:0]  cfg_num_blocks;
  logic              cfg_load;
  logic [DATA_W-1:0] s_axis_tdata;
  logic              s_axis_tvalid;
  logic              s_axis_tready;
  logic [DATA_W-1:0] m_axis_tdata;
  logic              m_axis_tvalid;
  logic              m_axis_tready;
  logic              m_axis_tlast;
  logic              is_first_block;
  logic              is_last_block;
  logic              frame_done;
  logic              cfg_err;
  logic [CNT_W-1:0]  blk_index;

  block_tracker #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .cfg_num_blocks (cfg_num_blocks),
    .cfg_load       (cfg_load),
    .s_axis_tdata   (s_axis_tdata),
    .s_axis_tvalid  (s_axis_tvalid),
    .s_axis_tready  (s_axis_tready),
    .m_axis_tdata   (m_axis_tdata),
    .m_axis_tvalid  (m_axis_tvalid),
    .m_axis_tready  (m_axis_tready),
    .m_axis_tlast   (m_axis_tlast),
    .is_first_block (is_first_block),
    .is_last_block  (is_last_block),
    .frame_done     (frame_done),
    .cfg_err        (cfg_err),
    .blk_index      (blk_index)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Scoreboard / reference model state.
  logic [DATA_W-1:0] send_q[$];
  logic [DATA_W:0]   recv_q[$];     // {tlast, tdata}
  logic [CNT_W-1:0]  model_idx = '0;
  logic [CNT_W-1:0]  model_len = '0;
  int                in_flight = 0;
  int                fd_count  = 0;
  int                fd_before = 0;
  bit                rand_ready = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock cycle of streaming: present the next queued beat, sample the
  // handshakes that will happen at the coming edge, then update the model.
  task automatic tick();
    logic            s_hs;
    logic            m_hs;
    logic            stall;
    logic [DATA_W:0] held;
    if (rand_ready) m_axis_tready = 1'($urandom_range(0, 1));
    if (send_q.size() > 0) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata  = send_q[0];
    end else begin
      s_axis_tvalid = 1'b0;
    end
    s_hs  = s_axis_tvalid && s_axis_tready;
    m_hs  = m_axis_tvalid && m_axis_tready;
    stall = m_axis_tvalid && !m_axis_tready;
    held  = {m_axis_tlast, m_axis_tdata};
    if (s_hs) begin
      check("is_first_at_beat", is_first_block, model_idx == '0);
      check("is_last_at_beat", is_last_block, model_idx == model_len - CNT_W'(1));
    end
    @(posedge clk);
    #1;
    if (s_hs) begin
      void'(send_q.pop_front());
      in_flight++;
      if (model_idx == model_len - CNT_W'(1)) model_idx = '0;
      else                                   model_idx = model_idx + CNT_W'(1);
    end
    if (m_hs) begin
      recv_q.push_back(held);
      in_flight--;
    end
    if (frame_done) fd_count++;
    if (stall) check("stall_hold", {m_axis_tvalid, m_axis_tlast, m_axis_tdata}, {1'b1, held});
    check("buffered_le_2", in_flight <= 2, 1);
    check("blk_index", blk_index, model_idx);
  endtask

  task automatic do_cfg(input logic [CNT_W-1:0] len);
    cfg_load       = 1'b1;
    cfg_num_blocks = len;
    @(posedge clk);
    #1;
    cfg_load  = 1'b0;
    model_len = len;
    model_idx = '0;
    in_flight = 0;
  endtask

  task automatic check_frame(input string tag, input logic [DATA_W-1:0] base, input int n);
    check({tag, "_count"}, recv_q.size(), n);
    for (int i = 0; i < n && i < recv_q.size(); i++)
      check(tag, recv_q[i], {1'(i == n - 1), DATA_W'(base + i)});
    recv_q.delete();
  endtask

  initial begin
    reset          = 1'b1;
    cfg_load       = 1'b0;
    cfg_num_blocks = '0;
    s_axis_tdata   = '0;
    s_axis_tvalid  = 1'b0;
    m_axis_tready  = 1'b1;

    // ---- Reset state -------------------------------------------------------
    repeat (2) @(posedge clk);
    #1;
    check("rst_s_ready", s_axis_tready, 0);
    check("rst_m_valid", m_axis_tvalid, 0);
    check("rst_m_tlast", m_axis_tlast, 0);
    check("rst_m_data", m_axis_tdata, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_cfg_err", cfg_err, 0);
    check("rst_is_first", is_first_block, 0);
    check("rst_is_last", is_last_block, 0);
    check("rst_blk_index", blk_index, 0);
    reset = 1'b0;
    tick();
    check("idle_s_ready", s_axis_tready, 0);

    // ---- Nominal frame: length 4, A0..A3, tready held high ----------------
    do_cfg(4);
    check("nom_s_ready", s_axis_tready, 1);
    check("nom_is_first", is_first_block, 1);
    check("nom_is_last", is_last_block, 0);
    for (int i = 0; i < 4; i++) send_q.push_back(32'hA0 + i);
    tick();
    check("nom_latency_valid", m_axis_tvalid, 1);
    check("nom_latency_data", m_axis_tdata, 32'hA0);
    tick();
    check("nom_thru_data", m_axis_tdata, 32'hA1);
    tick();
    tick();
    check("nom_last_data", m_axis_tdata, 32'hA3);
    check("nom_last_tlast", m_axis_tlast, 1);
    check("nom_drain_s_ready", s_axis_tready, 0);
    tick();
    check("nom_frame_done", frame_done, 1);
    check("nom_rearm_s_ready", s_axis_tready, 1);
    check("nom_rearm_is_first", is_first_block, 1);
    check("nom_empty", m_axis_tvalid, 0);
    tick();
    check("nom_frame_done_pulse", frame_done, 0);
    check_frame("nom_out", 32'hA0, 4);
    check("nom_fd_count", fd_count, 1);

    // ---- Backpressure: length 8, random tready ----------------------------
    do_cfg(8);
    fd_before = fd_count;
    for (int i = 0; i < 8; i++) send_q.push_back(32'hB000_0000 + i);
    rand_ready = 1'b1;
    for (int i = 0; i < 200 && recv_q.size() < 8; i++) tick();
    rand_ready    = 1'b0;
    m_axis_tready = 1'b1;
    tick();
    check_frame("bp_out", 32'hB000_0000, 8);
    check("bp_fd_count", fd_count, fd_before + 1);

    // ---- Single-block image ------------------------------------------------
    do_cfg(1);
    check("one_is_first", is_first_block, 1);
    check("one_is_last", is_last_block, 1);
    send_q.push_back(32'h55);
    tick();
    check("one_data", m_axis_tdata, 32'h55);
    check("one_tlast", m_axis_tlast, 1);
    check("one_s_ready", s_axis_tready, 0);
    tick();
    check("one_frame_done", frame_done, 1);
    check_frame("one_out", 32'h55, 1);

    // ---- Zero length --------------------------------------------------------
    do_cfg(0);
    check("zero_cfg_err", cfg_err, 1);
    check("zero_s_ready", s_axis_tready, 0);
    check("zero_is_first", is_first_block, 0);
    send_q.push_back(32'h77);
    for (int i = 0; i < 3; i++) begin
      tick();
      check("zero_s_ready_hold", s_axis_tready, 0);
      check("zero_m_valid", m_axis_tvalid, 0);
    end
    send_q.delete();
    s_axis_tvalid = 1'b0;
    do_cfg(3);
    check("rearm_cfg_err", cfg_err, 0);
    check("rearm_s_ready", s_axis_tready, 1);
    check("rearm_is_first", is_first_block, 1);

    // ---- Abort with two beats buffered ------------------------------------
    do_cfg(8);
    for (int i = 0; i < 3; i++) send_q.push_back(32'hC0 + i);
    m_axis_tready = 1'b1;
    tick();
    tick();
    m_axis_tready = 1'b0;
    tick();
    check("abort_pre_in_flight", in_flight, 2);
    check("abort_pre_s_ready", s_axis_tready, 0);
    check("abort_pre_data", m_axis_tdata, 32'hC1);
    check("abort_recv_c0", recv_q.size() == 1 && recv_q[0] == {1'b0, 32'hC0}, 1);
    recv_q.delete();
    fd_before     = fd_count;
    s_axis_tvalid = 1'b1;
    s_axis_tdata  = 32'hDEAD;
    m_axis_tready = 1'b1;
    do_cfg(6);
    check("abort_m_valid", m_axis_tvalid, 0);
    check("abort_blk_index", blk_index, 0);
    check("abort_s_ready", s_axis_tready, 1);
    check("abort_frame_done", frame_done, 0);
    for (int i = 0; i < 6; i++) send_q.push_back(32'hD0 + i);
    for (int i = 0; i < 30 && recv_q.size() < 6; i++) tick();
    tick();
    check_frame("abort_out", 32'hD0, 6);
    check("abort_fd_count", fd_count, fd_before + 1);

    // ---- Reset during a stalled frame -------------------------------------
    do_cfg(2);
    m_axis_tready = 1'b0;
    send_q.push_back(32'hE0);
    send_q.push_back(32'hE1);
    tick();
    tick();
    check("rmid_drain_s_ready", s_axis_tready, 0);
    m_axis_tready = 1'b1;
    tick();
    m_axis_tready = 1'b0;
    check("rmid_pre_tlast", m_axis_tlast, 1);
    check("rmid_pre_data", m_axis_tdata, 32'hE1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    recv_q.delete();
    in_flight = 0;
    model_idx = '0;
    check("rmid_s_ready", s_axis_tready, 0);
    check("rmid_m_valid", m_axis_tvalid, 0);
    check("rmid_m_tlast", m_axis_tlast, 0);
    check("rmid_m_data", m_axis_tdata, 0);
    check("rmid_frame_done", frame_done, 0);
    check("rmid_cfg_err", cfg_err, 0);
    check("rmid_is_first", is_first_block, 0);
    check("rmid_is_last", is_last_block, 0);
    check("rmid_blk_index", blk_index, 0);
    send_q.push_back(32'hF0);
    tick();
    tick();
    check("rmid_idle_s_ready", s_axis_tready, 0);
    check("rmid_idle_m_valid", m_axis_tvalid, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
